serial_tx_framer: RTL

//  Upstream companion of the serial byte receiver: buffers parallel bytes and

---
 rtl/serial_tx_framer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/serial_tx_framer.sv
// Buffered byte-to-serial framer: start, 8 data bits LSB first, odd parity, stop; idle-high line.
// Define SERIAL_TX_PAR_INJ_EN to add the par_inj input that forces an inverted parity bit per byte.
module serial_tx_framer #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
`ifdef SERIAL_TX_PAR_INJ_EN
  input  logic       par_inj,
`endif
  output logic       tx_ready,
  output logic       tx_line,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef SERIAL_TX_PAR_INJ_EN
  localparam int unsigned EW = 9;
`else
  localparam int unsigned EW = 8;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic            line_q, line_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [EW-1:0]   wr_entry, rd_entry;
  logic            push, pop, fifo_empty, bit_end, inj;

  assign push       = tx_valid & ready_q;
  assign fifo_empty = (count_q == CW'(0));
  assign bit_end    = (div_q == DW'(CLKS_PER_BIT - 1));
  assign rd_entry   = mem[rd_q];

`ifdef SERIAL_TX_PAR_INJ_EN
  assign wr_entry = {par_inj, tx_data};
  assign inj      = rd_entry[8];
`else
  assign wr_entry = tx_data;
  assign inj      = 1'b0;
`endif

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q] <= wr_entry;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      line_q  <= line_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; a pop happens on every transition into START
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_START;
          pop     = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_q == 3'd7)) state_d = S_PARITY;
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            state_d = S_START;
            pop     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Divider, bit counter, shifter and FIFO bookkeeping
  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;

    if ((state_q == S_IDLE) || bit_end) div_d = '0;
    else                                div_d = div_q + DW'(1);

    if ((state_q == S_DATA) && bit_end) begin
      bit_d   = bit_q + 3'd1;
      shreg_d = shreg_q >> 1;
    end

    if (pop) begin
      shreg_d = rd_entry[7:0];
      par_d   = (~^rd_entry[7:0]) ^ inj;
      rd_d    = rd_q + AW'(1);
    end
    if (push) wr_d = wr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Output decode from next state so the registered outputs track the state register
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      S_IDLE:   line_d = 1'b1;
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shreg_d[0];
      S_PARITY: line_d = par_d;
      S_STOP:   line_d = 1'b1;
      default:  line_d = 1'b1;
    endcase
    ready_d = (count_d != CW'(FIFO_DEPTH));
    busy_d  = (state_d != S_IDLE) || (count_d != CW'(0));
    done_d  = (state_d == S_STOP) && (div_d == DW'(CLKS_PER_BIT - 1));
  end

  assign tx_line    = line_q;
  assign tx_ready   = ready_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
